mac_sum_select: RTL and testbench



---
 rtl/mac_sum_select.sv | 158 +++++++++++++++
 tb/tb_mac_sum_select.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_sum_select.sv
// Sum-select / normalise-prep stage for the FMA datapath.
// S1 picks the positive magnitude of the wide adder result (true or
// complemented halves depending on the high-part sign) and fixes the sign.
// S2 counts leading zeros of that magnitude for the normaliser.
// Both stages carry a valid bit with ready/valid backpressure; a beat moves
// forward whenever the slot ahead is empty or is being drained this cycle.

// Leading-zero counter: position of the most significant set bit, folded
// into a zero count. An all-zero vector reports W and raises zero.
module mac_sum_select_lzc #(
  parameter int W  = 75,
  parameter int ZW = 7
) (
  input  logic [W-1:0]  vec,
  output logic [ZW-1:0] cnt,
  output logic          zero
);

  // Highest set bit wins; scanning upward lets the last hit overwrite.
  always_comb begin
    cnt = ZW'(W);
    for (int i = 0; i < W; i++) begin
      if (vec[i]) cnt = ZW'(W - 1 - i);
    end
  end

  assign zero = ~|vec;

endmodule

module mac_sum_select #(
  parameter int PARM_MANT = 23,
  parameter int PARM_EXP  = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [PARM_MANT+3:0]               high_sum_i,
  input  logic [PARM_MANT+3:0]               high_sum_inv_i,
  input  logic [2*PARM_MANT+1:0]             low_sum_i,
  input  logic [2*PARM_MANT+1:0]             low_sum_inv_i,
  input  logic                               sign_i,
  input  logic [PARM_EXP+1:0]                exp_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [3*PARM_MANT+5:0]             mant_o,
  output logic [$clog2(3*PARM_MANT+7)-1:0]   lzc_o,
  output logic                               zero_o,
  output logic                               sign_o,
  output logic [PARM_EXP+1:0]                exp_o
);

  localparam int W      = 3*PARM_MANT + 6;
  localparam int LW     = 2*PARM_MANT + 2;
  localparam int HW     = PARM_MANT + 4;
  localparam int ZW     = $clog2(W + 1);
  localparam int EW     = PARM_EXP + 2;
  localparam int STAGES = 2;

  // Payload carried from S1 into S2.
  typedef struct packed {
    logic [W-1:0]  mant;
    logic          sign;
    logic [EW-1:0] exp;
  } sel_t;

  // Per-stage valid bits: [1] = S1 slot, [2] = S2 slot (drives out_valid_o).
  logic [STAGES:1] vld_pipe;

  logic   s2_free;
  logic   s1_adv;
  logic   accept;
  logic   neg;
  sel_t   sel_d;
  sel_t   s1_q;

  logic [W-1:0]  s2_mant_q;
  logic [ZW-1:0] s2_lzc_q;
  logic          s2_zero_q;
  logic          s2_sign_q;
  logic [EW-1:0] s2_exp_q;

  logic [ZW-1:0] lzc_d;
  logic          zero_d;

  // Handshake: S2 drains on out_ready or when empty; S1 moves up when S2
  // frees; the input is ready when S1 is empty or leaving this cycle.
  always_comb begin
    s2_free    = ~vld_pipe[2] | out_ready_i;
    s1_adv     = vld_pipe[1] & s2_free;
    in_ready_o = ~vld_pipe[1] | s1_adv;
    accept     = in_valid_i & in_ready_o;
  end

  // A set MSB in the high part means the sum went negative; the incrementer
  // already supplied the complemented halves, so just pick them.
  always_comb begin
    neg        = high_sum_i[HW-1];
    sel_d.mant = neg ? {high_sum_inv_i, low_sum_inv_i} : {high_sum_i, low_sum_i};
    sel_d.sign = sign_i ^ neg;
    sel_d.exp  = exp_i;
  end

  // Valid bits clear asynchronously so in-flight beats vanish on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= accept | (vld_pipe[1] & ~s1_adv);
      vld_pipe[2] <= s1_adv | (vld_pipe[2] & ~out_ready_i);
    end
  end

  // S1 payload: loads on every accepted beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= '0;
    end else if (accept) begin
      s1_q <= sel_d;
    end
  end

  mac_sum_select_lzc #(
    .W  (W),
    .ZW (ZW)
  ) u_lzc (
    .vec  (s1_q.mant),
    .cnt  (lzc_d),
    .zero (zero_d)
  );

  // S2 payload: loads only when S1 moves up, so a stalled output holds.
  // Reset leaves a clean all-zero result with the zero flag raised.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_mant_q <= '0;
      s2_lzc_q  <= '0;
      s2_zero_q <= 1'b1;
      s2_sign_q <= 1'b0;
      s2_exp_q  <= '0;
    end else if (s1_adv) begin
      s2_mant_q <= s1_q.mant;
      s2_lzc_q  <= lzc_d;
      s2_zero_q <= zero_d;
      s2_sign_q <= s1_q.sign;
      s2_exp_q  <= s1_q.exp;
    end
  end

  assign out_valid_o = vld_pipe[2];
  assign mant_o      = s2_mant_q;
  assign lzc_o       = s2_lzc_q;
  assign zero_o      = s2_zero_q;
  assign sign_o      = s2_sign_q;
  assign exp_o       = s2_exp_q;

endmodule

// File: tb/tb_mac_sum_select.sv
// Bench for mac_sum_select: directed beats with literal results, backpressure,
// streaming and mid-stream reset, then random traffic against a queue model.
module tb_mac_sum_select;

  localparam int M  = 23;
  localparam int E  = 8;
  localparam int W  = 3*M + 6;
  localparam int LW = 2*M + 2;
  localparam int HW = M + 4;
  localparam int ZW = $clog2(W + 1);
  localparam int EW = E + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [HW-1:0] high_sum, high_sum_inv;
  logic [LW-1:0] low_sum, low_sum_inv;
  logic          sign_in;
  logic [EW-1:0] exp_in;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  mant;
  logic [ZW-1:0] lzc;
  logic          zero;
  logic          sign_out;
  logic [EW-1:0] exp_out;

  always #5 clk = ~clk;

  mac_sum_select #(.PARM_MANT(M), .PARM_EXP(E)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .high_sum_i     (high_sum),
    .high_sum_inv_i (high_sum_inv),
    .low_sum_i      (low_sum),
    .low_sum_inv_i  (low_sum_inv),
    .sign_i         (sign_in),
    .exp_i          (exp_in),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .mant_o         (mant),
    .lzc_o          (lzc),
    .zero_o         (zero),
    .sign_o         (sign_out),
    .exp_o          (exp_out)
  );

  typedef struct packed {
    logic [HW-1:0] h, hi;
    logic [LW-1:0] l, li;
    logic          s;
    logic [EW-1:0] e;
  } in_t;

  typedef struct {
    logic [W-1:0]  mant;
    logic [ZW-1:0] lzc;
    logic          zero, sign;
    logic [EW-1:0] exp;
    int            cyc;
  } beat_t;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic in_t mk(input logic [HW-1:0] h, input logic [HW-1:0] hi,
                             input logic [LW-1:0] l, input logic [LW-1:0] li,
                             input logic s, input logic [EW-1:0] e);
    in_t b;
    b.h = h; b.hi = hi; b.l = l; b.li = li; b.s = s; b.e = e;
    return b;
  endfunction

  // Reference: pick magnitude by the high-part sign, count zeros above the
  // most significant one.
  function automatic beat_t model(input in_t b);
    beat_t r;
    int    msb;
    logic  neg;
    neg    = b.h[HW-1];
    r.mant = neg ? {b.hi, b.li} : {b.h, b.l};
    r.sign = b.s ^ neg;
    r.exp  = b.e;
    msb    = 0;
    for (int i = 0; i < W; i++) if (r.mant[i]) msb = i + 1;
    r.lzc  = ZW'(W - msb);
    r.zero = (r.mant == '0);
    r.cyc  = 0;
    return r;
  endfunction

  function automatic logic [W-1:0] shifted_rand();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return W'(r) >> $urandom_range(0, W + 1);
  endfunction

  function automatic in_t rand_in();
    logic [W-1:0] a, c;
    in_t b;
    a = shifted_rand();
    c = shifted_rand();
    b.h  = a[W-1:LW];
    b.l  = a[LW-1:0];
    b.hi = c[W-1:LW];
    b.li = c[LW-1:0];
    if ($urandom_range(0, 1) == 1) b.h[HW-1] = 1'b1;
    b.s = 1'(($urandom));
    b.e = EW'($urandom);
    return b;
  endfunction

  task automatic apply(input in_t b);
    high_sum = b.h; high_sum_inv = b.hi;
    low_sum  = b.l; low_sum_inv  = b.li;
    sign_in  = b.s; exp_in       = b.e;
  endtask

  // ---------------- model + compare process ----------------
  beat_t q[$];
  beat_t pend_beat;
  bit    pend_acc, pend_pop;
  int    cyc  = 0;
  int    pops = 0;
  logic  exp_valid, exp_ready;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      pend_acc = 0;
      pend_pop = 0;
      chk("reset_state", {out_valid, in_ready, mant, lzc, zero, sign_out, exp_out},
          {1'b0, 1'b1, {W{1'b0}}, {ZW{1'b0}}, 1'b1, 1'b0, {EW{1'b0}}});
    end else begin
      if (pend_pop) begin
        void'(q.pop_front());
        pops++;
      end
      if (pend_acc) q.push_back(pend_beat);
      exp_valid = 1'b0;
      if (q.size() > 0) exp_valid = (cyc - q[0].cyc) >= 2;
      exp_ready = (q.size() < 2) || out_ready;
      chk("out_valid", out_valid, exp_valid);
      chk("in_ready", in_ready, exp_ready);
      if (exp_valid && out_valid)
        chk("beat_data", {mant, lzc, zero, sign_out, exp_out},
            {q[0].mant, q[0].lzc, q[0].zero, q[0].sign, q[0].exp});
      pend_acc  = in_valid && exp_ready;
      pend_beat = model(mk(high_sum, high_sum_inv, low_sum, low_sum_inv, sign_in, exp_in));
      pend_beat.cyc = cyc;
      pend_pop  = exp_valid && out_ready;
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  // Present a beat and hold it until accepted (bounded); returns at edge+1.
  task automatic send(input in_t b);
    bit ok;
    ok = 0;
    apply(b);
    in_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string nm, input in_t b, input logic [94:0] expv);
    apply(b);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk(nm, {out_valid, mant, lzc, zero, sign_out, exp_out}, expv);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t m;
    int    p0;
    logic [W-1:0] big;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    apply(mk('0, '0, '0, '0, 1'b0, '0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Pin the model to hand-computed values.
    m = model(mk('0, '0, 48'd1, '0, 1'b0, 10'd5));
    chk("model_pos", {m.mant, m.lzc, m.zero, m.sign}, {75'd1, 7'd74, 1'b0, 1'b0});
    m = model(mk(27'h4000000, 27'h1, '0, '0, 1'b0, '0));
    big = 75'd1 << 48;
    chk("model_neg", {m.mant, m.lzc, m.zero, m.sign}, {big, 7'd26, 1'b0, 1'b1});
    m = model(mk('0, '0, '0, '0, 1'b0, '0));
    chk("model_zero", {m.lzc, m.zero}, {7'd75, 1'b1});

    // Directed beats with literal results, two cycles after accept.
    out_ready = 1'b1;
    directed("pos_path", mk('0, '0, 48'd1, '0, 1'b0, 10'd5),
             {1'b1, 75'd1, 7'd74, 1'b0, 1'b0, 10'd5});
    directed("neg_path", mk(27'h4000000, 27'h1, 48'hFFFF, '0, 1'b0, 10'd3),
             {1'b1, big, 7'd26, 1'b0, 1'b1, 10'd3});
    directed("zero_path", mk('0, 27'h5, '0, 48'h7, 1'b1, 10'd9),
             {1'b1, 75'd0, 7'd75, 1'b1, 1'b1, 10'd9});

    // Backpressure: A and B fill both slots, C stalls, then all drain.
    out_ready = 1'b0;
    p0 = pops;
    send(rand_in());
    send(rand_in());
    apply(rand_in());
    in_valid = 1'b1;
    @(negedge clk);
    chk("bp_full_ready", in_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    send(mk(high_sum, high_sum_inv, low_sum, low_sum_inv, sign_in, exp_in));
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("bp_drain_count", pops - p0, 3);
    @(posedge clk);
    #1;

    // Streaming: ten back-to-back beats.
    p0 = pops;
    for (int i = 0; i < 10; i++) send(rand_in());
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("stream_count", pops - p0, 10);
    @(posedge clk);
    #1;

    // Reset between edges with two beats in flight.
    send(rand_in());
    send(rand_in());
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async", {out_valid, in_ready, zero}, 3'b111 & 3'b011);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    send(rand_in());
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Random traffic with varying backpressure phases.
    for (int i = 0; i < 600; i++) begin
      apply(rand_in());
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = (i % 100 < 50) ? ($urandom_range(0, 3) != 0)
                                 : ($urandom_range(0, 2) == 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("final_empty", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
